// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default timing parameters and
// the frame-length helper used by both the transmitter and its bench.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int unsigned UART_DIVISOR   = 868;
    localparam int unsigned UART_STOP_BITS = 1;

    function automatic int unsigned frame_len(input int unsigned data_width,
                                              input int unsigned stop_bits,
                                              input int unsigned divisor);
        return (1 + data_width + stop_bits) * divisor;
    endfunction

endpackage

// File: rtl/axis_uart_tx.sv
// AXI-Stream byte sink that serialises each accepted byte as an 8N1/8N2 UART
// frame on a registered txd output.
module axis_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIVISOR    = UART_DIVISOR,
    parameter int unsigned STOP_BITS  = UART_STOP_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tvalid,
    output logic                  tready,
    output logic                  txd,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(DIVISOR);
    localparam int unsigned BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(DIVISOR - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    generate
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("axis_uart_tx: DIVISOR must be >= 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("axis_uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_t           state, state_n;
    logic [CW-1:0]         baud;
    logic [BW-1:0]         bitc;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  txd_q;
    logic                  txd_n;
    logic                  accept;
    logic                  bit_end;

    always_comb begin
        state_n = state;
        txd_n   = 1'b1;
        bit_end = (baud == BAUD_LAST);
        tready  = (state == IDLE) && !reset;
        accept  = tready && tvalid;
        busy    = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) state_n = START;
            end
            START: begin
                txd_n = 1'b0;
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                txd_n = shreg[0];
                if (bit_end && bitc == DATA_LAST) state_n = STOP;
            end
            STOP: begin
                if (bit_end && bitc == STOP_LAST) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // txd is registered from the current state, so the line lags the FSM by one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            baud  <= '0;
            bitc  <= '0;
            shreg <= '0;
            txd_q <= 1'b1;
        end else begin
            state <= state_n;
            txd_q <= txd_n;
            if (accept) begin
                shreg <= tdata;
                baud  <= '0;
                bitc  <= '0;
            end else if (state != IDLE) begin
                baud <= bit_end ? '0 : baud + 1'b1;
                if (bit_end) begin
                    if (state == DATA) shreg <= shreg >> 1;
                    // The bit counter restarts on every phase change; the stop phase reuses it.
                    if (state_n != state) bitc <= '0;
                    else if (state != START) bitc <= bitc + 1'b1;
                end
            end
        end
    end

    assign txd = txd_q;

endmodule

// File: tb/tb_axis_uart_tx.sv
// Randomised self-checking bench for axis_uart_tx: a line-level UART decoder
// and a byte scoreboard model the expected serial behaviour.
module tb_axis_uart_tx;
    import uart_pkg::*;

    localparam int DW  = 8;
    localparam int DIV = 4;
    localparam int SB  = 1;
    localparam int FL  = int'(frame_len(DW, SB, DIV));

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic [DW-1:0] tdata  = '0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic          txd;
    logic          busy;

    always #5 clk = ~clk;

    axis_uart_tx #(.DATA_WIDTH(DW), .DIVISOR(DIV), .STOP_BITS(SB)) dut (
        .clk    (clk),
        .reset  (reset),
        .tdata  (tdata),
        .tvalid (tvalid),
        .tready (tready),
        .txd    (txd),
        .busy   (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] sb_q[$];
    int         acc_cyc[$];
    logic [7:0] rx_q[$];
    logic [7:0] last_byte = '0;
    int         decoded   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Records every handshake with the clock index of the accepting edge.
    always @(posedge clk) begin
        if (reset) sb_q.delete();
        else if (tvalid && tready) begin
            sb_q.push_back(tdata);
            acc_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    // Line decoder: finds the start edge, samples each bit at mid-bit.
    bit         m_act  = 1'b0;
    int         m_t    = 0;
    logic [7:0] m_byte = '0;
    always @(negedge clk) begin
        int j;
        if (reset) m_act = 1'b0;
        else if (!m_act) begin
            if (txd === 1'b0) begin
                m_act  = 1'b1;
                m_t    = 0;
                m_byte = '0;
                if (acc_cyc.size() > 0) check("start_latency", 32'((cyc - 1) - acc_cyc[$]), 32'd1);
                else check("start_without_accept", 32'd0, 32'd1);
            end
        end else m_t++;
        if (m_act && (m_t % DIV) == DIV / 2) begin
            j = m_t / DIV;
            if (j == 0) check("start_bit", 32'(txd), 32'd0);
            else if (j <= DW) m_byte[j-1] = txd;
            else begin
                check("stop_bit", 32'(txd), 32'd1);
                if (j == DW + SB) begin
                    if (sb_q.size() > 0) check("byte", 32'(m_byte), 32'(sb_q.pop_front()));
                    else check("byte_unexpected", 32'd1, 32'd0);
                    rx_q.push_back(m_byte);
                    last_byte = m_byte;
                    decoded++;
                    m_act = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int i;
        i = 0;
        @(negedge clk);
        while (!tready && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (!tready) check("send_timeout", 32'd0, 32'd1);
        tvalid = 1'b1;
        tdata  = b;
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while ((busy || m_act || sb_q.size() != 0) && i < 1000) begin
            @(negedge clk);
            i++;
        end
        if (i >= 1000) check("wait_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] fifo_q[$];
        logic [7:0] exp_q[$];
        int lo, bz, hi, n0, d0, a0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tready", 32'(tready), 32'd0);
            check("rst_txd", 32'(txd), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_tready", 32'(tready), 32'd1);

        // Idle with tvalid low: line stays high, nothing starts
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("idle_txd", 32'(txd), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Single byte 0xA5
        lo = 0;
        bz = 0;
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = 8'hA5;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) tvalid = 1'b0;
            if (!tready) lo++;
            if (busy) bz++;
            if (tready && lo > 0) break;
        end
        check("a5_tready_low", 32'(lo), 32'd40);
        check("a5_busy_high", 32'(bz), 32'd40);
        wait_done();
        check("a5_decoded", 32'(last_byte), 32'hA5);

        // Back-to-back 0x00 then 0xFF with tvalid held
        n0 = acc_cyc.size();
        hi = 0;
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = 8'h00;
        for (int i = 0; i < 200 && acc_cyc.size() < n0 + 2; i++) begin
            @(negedge clk);
            if (acc_cyc.size() == n0 + 1) begin
                tdata = 8'hFF;
                if (tready) hi++;
            end
        end
        tvalid = 1'b0;
        if (acc_cyc.size() == n0 + 2) check("b2b_period", 32'(acc_cyc[n0+1] - acc_cyc[n0]), 32'(FL + 1));
        else check("b2b_second_accept", 32'd0, 32'd1);
        check("b2b_tready_gap", 32'(hi), 32'd1);
        wait_done();
        check("b2b_last", 32'(last_byte), 32'hFF);

        // Input changes while busy are ignored
        n0 = acc_cyc.size();
        send(8'h3C);
        repeat (5) @(negedge clk);
        tdata = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tvalid = ~tvalid;
        end
        tvalid = 1'b0;
        wait_done();
        check("hold_decoded", 32'(last_byte), 32'h3C);
        check("hold_accepts", 32'(acc_cyc.size() - n0), 32'd1);

        // Reset during DATA bit 3 of 0x81, then a clean 0x55 frame
        send(8'h81);
        a0 = acc_cyc[$];
        for (int i = 0; i < 100 && cyc < a0 + 19; i++) @(negedge clk);
        check("abort_bit3", 32'(txd), 32'd0);
        d0 = decoded;
        reset = 1'b1;
        @(negedge clk);
        check("abort_txd", 32'(txd), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tready", 32'(tready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", 32'(tready), 32'd1);
        send(8'h55);
        wait_done();
        check("after_abort_byte", 32'(last_byte), 32'h55);
        check("after_abort_count", 32'(decoded - d0), 32'd1);

        // Fifo drain: 32 random bytes decoded in order
        for (int i = 0; i < 32; i++) begin
            fifo_q.push_back(8'($urandom_range(0, 255)));
            exp_q.push_back(fifo_q[$]);
        end
        rx_q.delete();
        d0 = decoded;
        for (int i = 0; i < 3000 && fifo_q.size() > 0; i++) begin
            @(negedge clk);
            tvalid = 1'b1;
            tdata  = fifo_q[0];
            if (tready) begin
                @(posedge clk);
                void'(fifo_q.pop_front());
            end
        end
        @(negedge clk);
        tvalid = 1'b0;
        wait_done();
        check("fifo_count", 32'(decoded - d0), 32'd32);
        for (int i = 0; i < 32 && i < rx_q.size(); i++) check("fifo_byte", 32'(rx_q[i]), 32'(exp_q[i]));
        check("fifo_empty", 32'(fifo_q.size() == 0), 32'd1);
        check("fifo_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
